// File: rtl/axis_fifo_sync_prog_if.sv
// AXI-Stream handshake bundle shared by both sides of axis_fifo_sync_prog.
// tlast is present only when AXIS_FIFO_SYNC_PROG_TLAST_EN is defined.
interface axis_fifo_sync_prog_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
`else
    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
`endif
endinterface

// File: rtl/axis_fifo_sync_prog.sv
// Synchronous first-word-fall-through AXI-Stream FIFO with programmable thresholds,
// sticky overflow/underflow flags and flush. Define AXIS_FIFO_SYNC_PROG_TLAST_EN for tlast/packet_count.
module axis_fifo_sync_prog #(
    parameter int    DATA_WIDTH          = 32,
    parameter int    DEPTH               = 16,
    parameter int    ALMOST_FULL_THRESH  = DEPTH - 2,
    parameter int    ALMOST_EMPTY_THRESH = 2,
    parameter string ALWAYS_READY        = "FALSE",
    parameter string ALWAYS_VALID        = "FALSE",
    localparam int   CW                  = $clog2(DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic                  clear_flags,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow_sticky,
    output logic                  underflow_sticky,
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
    output logic [CW-1:0]         packet_count,
`endif
    axis_fifo_sync_prog_if.slave  s_axis,
    axis_fifo_sync_prog_if.master m_axis
);

    localparam int AW = $clog2(DEPTH);
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif
    localparam bit            AR    = (ALWAYS_READY == "TRUE");
    localparam bit            AV    = (ALWAYS_VALID == "TRUE");
    localparam logic [CW-1:0] AF_TH = CW'(ALMOST_FULL_THRESH);
    localparam logic [CW-1:0] AE_TH = CW'(ALMOST_EMPTY_THRESH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [MW-1:0] mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic          wr_en;
    logic          rd_en;
    logic          ovf_set;
    logic          udf_set;

    // Status is derived purely from the registered pointers.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (count == '0);
    assign full         = (count == FULL_CNT);
    assign almost_empty = (count <= AE_TH);
    assign almost_full  = (count >= AF_TH);

    assign wr_en   = s_axis.tvalid && !full && !flush;
    assign rd_en   = m_axis.tready && !empty && !flush;
    assign ovf_set = AR && s_axis.tvalid && full && !flush;
    assign udf_set = AV && m_axis.tready && empty && !flush;

`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
    assign wr_word = {s_axis.tlast, s_axis.tdata};
`else
    assign wr_word = s_axis.tdata;
`endif
    assign rd_word = mem[rd_ptr[AW-1:0]];

    assign s_axis.tready = AR ? 1'b1 : !full;
    assign m_axis.tvalid = AV ? 1'b1 : !empty;
    assign m_axis.tdata  = (AV && empty) ? '0 : rd_word[DATA_WIDTH-1:0];
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
    assign m_axis.tlast  = (AV && empty) ? 1'b0 : rd_word[DATA_WIDTH];
`endif

    // Storage carries no reset: contents are meaningless once the pointers are cleared.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    // A new error event wins over a clear arriving in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_sticky  <= 1'b0;
            underflow_sticky <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_sticky <= 1'b1;
            end else if (clear_flags) begin
                overflow_sticky <= 1'b0;
            end
            if (udf_set) begin
                underflow_sticky <= 1'b1;
            end else if (clear_flags) begin
                underflow_sticky <= 1'b0;
            end
        end
    end

`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
    logic pkt_in;
    logic pkt_out;

    assign pkt_in  = wr_en && s_axis.tlast;
    assign pkt_out = rd_en && rd_word[DATA_WIDTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            packet_count <= '0;
        end else if (flush) begin
            packet_count <= '0;
        end else begin
            case ({pkt_in, pkt_out})
                2'b10:   packet_count <= packet_count + CW'(1);
                2'b01:   packet_count <= packet_count - CW'(1);
                default: packet_count <= packet_count;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_axis_fifo_sync_prog.sv
// Self-checking bench: a blocking FIFO and an always-ready/always-valid FIFO, scoreboard-checked.
module tb_axis_fifo_sync_prog;

    logic aclk;
    logic aresetn;

    logic       flush0, clr0, empty0, full0, ae0, af0, ovf0, udf0;
    logic [4:0] count0;
    logic       flush1, clr1, empty1, full1, ae1, af1, ovf1, udf1;
    logic [4:0] count1;
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
    logic [4:0] pc0, pc1;
`endif

    axis_fifo_sync_prog_if #(.DATA_WIDTH(32)) s0 ();
    axis_fifo_sync_prog_if #(.DATA_WIDTH(32)) m0 ();
    axis_fifo_sync_prog_if #(.DATA_WIDTH(32)) s1 ();
    axis_fifo_sync_prog_if #(.DATA_WIDTH(32)) m1 ();

    axis_fifo_sync_prog #(.DATA_WIDTH(32), .DEPTH(16)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .flush(flush0), .clear_flags(clr0),
        .count(count0), .empty(empty0), .full(full0), .almost_empty(ae0), .almost_full(af0),
        .overflow_sticky(ovf0), .underflow_sticky(udf0),
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
        .packet_count(pc0),
`endif
        .s_axis(s0), .m_axis(m0)
    );

    axis_fifo_sync_prog #(.DATA_WIDTH(32), .DEPTH(16), .ALWAYS_READY("TRUE"), .ALWAYS_VALID("TRUE")) dut1 (
        .aclk(aclk), .aresetn(aresetn), .flush(flush1), .clear_flags(clr1),
        .count(count1), .empty(empty1), .full(full1), .almost_empty(ae1), .almost_full(af1),
        .overflow_sticky(ovf1), .underflow_sticky(udf1),
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
        .packet_count(pc1),
`endif
        .s_axis(s1), .m_axis(m1)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] q[$];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] st;
        logic [10:0] ex;
        #2;
        st = {count0, empty0, full0, ae0, af0, ovf0, udf0};
        ex = {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (st !== ex) begin n_err++; $display("FAIL reset_status0 got %h want %h", st, ex); end
        n_cmp++;
        if ({s0.tready, m0.tvalid} !== 2'b10) begin
            n_err++; $display("FAIL reset_hs0 got %b want 10", {s0.tready, m0.tvalid});
        end
        st = {count1, empty1, full1, ae1, af1, ovf1, udf1};
        n_cmp++;
        if (st !== ex) begin n_err++; $display("FAIL reset_status1 got %h want %h", st, ex); end
        n_cmp++;
        if ({s1.tready, m1.tvalid, m1.tdata} !== {2'b11, 32'h0}) begin
            n_err++; $display("FAIL reset_hs1 got %b %b %h want 1 1 0", s1.tready, m1.tvalid, m1.tdata);
        end
        cyc();
        cyc();
        aresetn = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [5:0] st;
        logic [5:0] ex;
        logic [32:0] e;
        m0.tready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            s0.tvalid = 1'b1;
            s0.tdata  = 32'(i);
            n_cmp++;
            if (s0.tready !== 1'b1) begin n_err++; $display("FAIL fill_tready[%0d] got %b want 1", i, s0.tready); end
            q.push_back({1'b0, 32'(i)});
            cyc();
            st = {count0, full0, af0, ae0};
            ex = {5'(i), (i == 16), (i >= 14), (i <= 2)} ;
            n_cmp++;
            if (st !== ex || s0.tready !== (i != 16)) begin
                n_err++; $display("FAIL fill_status[%0d] got %b tready %b want %b tready %b", i, st, s0.tready, ex, (i != 16));
            end
        end
        s0.tdata = 32'h99;
        cyc();
        s0.tvalid = 1'b0;
        n_cmp++;
        if ({count0, ovf0} !== {5'd16, 1'b0}) begin
            n_err++; $display("FAIL fill_blocked got count %0d ovf %b want 16 0", count0, ovf0);
        end
        m0.tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            e = q.pop_front();
            n_cmp++;
            if (m0.tvalid !== 1'b1 || m0.tdata !== e[31:0]) begin
                n_err++; $display("FAIL drain[%0d] got %b %h want 1 %h", i, m0.tvalid, m0.tdata, e[31:0]);
            end
            cyc();
        end
        m0.tready = 1'b0;
        n_cmp++;
        if ({empty0, m0.tvalid, count0} !== {2'b10, 5'd0}) begin
            n_err++; $display("FAIL drain_empty got %b %b %0d want 1 0 0", empty0, m0.tvalid, count0);
        end
    endtask

    task automatic test_streaming();
        int sent = 0;
        int got  = 0;
        logic [32:0] e;
        m0.tready = 1'b1;
        for (int c = 0; c < 150 && (sent < 100 || q.size() != 0); c++) begin
            s0.tvalid = (sent < 100);
            s0.tdata  = 32'h1000 + 32'(sent);
            n_cmp++;
            if (count0 !== 5'(q.size()) || m0.tvalid !== (q.size() != 0)) begin
                n_err++; $display("FAIL stream_count[%0d] got %0d vld %b want %0d", c, count0, m0.tvalid, q.size());
            end
            if (m0.tvalid && m0.tready && q.size() != 0) begin
                e = q.pop_front();
                got++;
                n_cmp++;
                if (m0.tdata !== e[31:0]) begin
                    n_err++; $display("FAIL stream_data[%0d] got %h want %h", got, m0.tdata, e[31:0]);
                end
            end
            if (s0.tvalid && s0.tready) begin
                q.push_back({1'b0, s0.tdata});
                sent++;
            end
            cyc();
        end
        s0.tvalid = 1'b0;
        m0.tready = 1'b0;
        n_cmp++;
        if (got != 100) begin n_err++; $display("FAIL stream_total got %0d want 100", got); end
    endtask

    task automatic test_flush();
        logic [32:0] e;
        m0.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s0.tvalid = 1'b1;
            s0.tdata  = 32'h50 + 32'(i);
            cyc();
        end
        s0.tdata = 32'h77;
        flush0   = 1'b1;
        cyc();
        flush0    = 1'b0;
        s0.tvalid = 1'b0;
        n_cmp++;
        if ({count0, empty0, ovf0} !== {5'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL flush_state got %0d %b %b want 0 1 0", count0, empty0, ovf0);
        end
        s0.tvalid = 1'b1;
        s0.tdata  = 32'hA5;
        q.push_back({1'b0, 32'hA5});
        cyc();
        s0.tvalid = 1'b0;
        e = q.pop_front();
        n_cmp++;
        if ({m0.tvalid, m0.tdata, count0} !== {1'b1, e[31:0], 5'd1}) begin
            n_err++; $display("FAIL flush_after got %b %h %0d want 1 %h 1", m0.tvalid, m0.tdata, count0, e[31:0]);
        end
        m0.tready = 1'b1;
        cyc();
        m0.tready = 1'b0;
        n_cmp++;
        if (empty0 !== 1'b1) begin n_err++; $display("FAIL flush_read_empty got %b want 1", empty0); end
    endtask

    task automatic test_always_ready();
        logic [32:0] e;
        m1.tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s1.tvalid = 1'b1;
            s1.tdata  = 32'h200 + 32'(i);
            q.push_back({1'b0, s1.tdata});
            cyc();
        end
        s1.tdata = 32'hDEAD;
        cyc();
        s1.tvalid = 1'b0;
        n_cmp++;
        if ({ovf1, count1, full1, s1.tready} !== {1'b1, 5'd16, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL ar_overflow got ovf %b cnt %0d full %b rdy %b want 1 16 1 1", ovf1, count1, full1, s1.tready);
        end
        m1.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = q.pop_front();
            n_cmp++;
            if (m1.tdata !== e[31:0]) begin n_err++; $display("FAIL ar_drain[%0d] got %h want %h", i, m1.tdata, e[31:0]); end
            cyc();
        end
        m1.tready = 1'b0;
        n_cmp++;
        if ({count1, udf1} !== {5'd0, 1'b0}) begin
            n_err++; $display("FAIL ar_drained got %0d udf %b want 0 0", count1, udf1);
        end
    endtask

    task automatic test_always_valid();
        n_cmp++;
        if ({m1.tvalid, m1.tdata} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL av_empty got %b %h want 1 0", m1.tvalid, m1.tdata);
        end
        m1.tready = 1'b1;
        cyc();
        m1.tready = 1'b0;
        n_cmp++;
        if ({udf1, count1, empty1} !== {1'b1, 5'd0, 1'b1}) begin
            n_err++; $display("FAIL av_underflow got udf %b cnt %0d empty %b want 1 0 1", udf1, count1, empty1);
        end
    endtask

    task automatic test_clear_flags();
        clr1 = 1'b1;
        cyc();
        clr1 = 1'b0;
        n_cmp++;
        if ({ovf1, udf1} !== 2'b00) begin n_err++; $display("FAIL clr_pulse got %b%b want 00", ovf1, udf1); end
        for (int i = 0; i < 16; i++) begin
            s1.tvalid = 1'b1;
            s1.tdata  = 32'h400 + 32'(i);
            cyc();
        end
        n_cmp++;
        if (ovf1 !== 1'b0) begin n_err++; $display("FAIL clr_refill_ovf got %b want 0", ovf1); end
        s1.tdata = 32'hDEAD;
        clr1     = 1'b1;
        cyc();
        clr1      = 1'b0;
        s1.tvalid = 1'b0;
        n_cmp++;
        if (ovf1 !== 1'b1) begin n_err++; $display("FAIL clr_set_priority got %b want 1", ovf1); end
        flush1 = 1'b1;
        cyc();
        flush1 = 1'b0;
        n_cmp++;
        if ({count1, empty1, ovf1} !== {5'd0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL flush_keeps_flag got %0d %b %b want 0 1 1", count1, empty1, ovf1);
        end
    endtask

`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
    task automatic test_tlast();
        logic [32:0] e;
        int exp_pc;
        m0.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s0.tvalid = 1'b1;
            s0.tdata  = 32'h300 + 32'(i);
            s0.tlast  = (i == 2 || i == 4);
            q.push_back({s0.tlast, s0.tdata});
            cyc();
        end
        s0.tvalid = 1'b0;
        s0.tlast  = 1'b0;
        exp_pc = 2;
        n_cmp++;
        if (pc0 !== 5'd2) begin n_err++; $display("FAIL tlast_pc_full got %0d want 2", pc0); end
        m0.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = q.pop_front();
            n_cmp++;
            if ({m0.tlast, m0.tdata} !== e) begin
                n_err++; $display("FAIL tlast_read[%0d] got %b %h want %b %h", i, m0.tlast, m0.tdata, e[32], e[31:0]);
            end
            if (e[32]) exp_pc--;
            cyc();
            n_cmp++;
            if (pc0 !== 5'(exp_pc)) begin n_err++; $display("FAIL tlast_pc[%0d] got %0d want %0d", i, pc0, exp_pc); end
        end
        m0.tready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        m0.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s0.tvalid = 1'b1;
            s0.tdata  = 32'h600 + 32'(i);
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
            s0.tlast  = (i == 1);
`endif
            cyc();
        end
        #2;
        aresetn = 1'b0;
        #1;
        s0.tvalid = 1'b0;
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
        s0.tlast  = 1'b0;
        n_cmp++;
        if ({pc0, pc1} !== 10'd0) begin n_err++; $display("FAIL rstmid_pc got %0d %0d want 0 0", pc0, pc1); end
`endif
        n_cmp++;
        if ({count0, empty0, full0, ae0, af0, ovf0, udf0, s0.tready, m0.tvalid} !== {5'd0, 8'b10100010}) begin
            n_err++; $display("FAIL rstmid_dut0 got cnt %0d e %b f %b rdy %b vld %b", count0, empty0, full0, s0.tready, m0.tvalid);
        end
        n_cmp++;
        if ({count1, ovf1, udf1, m1.tvalid, m1.tdata} !== {5'd0, 3'b001, 32'h0}) begin
            n_err++; $display("FAIL rstmid_dut1 got cnt %0d ovf %b udf %b vld %b data %h", count1, ovf1, udf1, m1.tvalid, m1.tdata);
        end
        cyc();
        aresetn = 1'b1;
        cyc();
    endtask

    initial begin
        aresetn   = 1'b0;
        flush0    = 1'b0;
        clr0      = 1'b0;
        flush1    = 1'b0;
        clr1      = 1'b0;
        s0.tvalid = 1'b0;
        s0.tdata  = '0;
        m0.tready = 1'b0;
        s1.tvalid = 1'b0;
        s1.tdata  = '0;
        m1.tready = 1'b0;
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
        s0.tlast  = 1'b0;
        s1.tlast  = 1'b0;
`endif
        test_reset();
        test_fill_drain();
        test_streaming();
        test_flush();
        test_always_ready();
        test_always_valid();
        test_clear_flags();
`ifdef AXIS_FIFO_SYNC_PROG_TLAST_EN
        test_tlast();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
